// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and width helper for the serial magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} cmp_res_t;

    // Width of a counter that must hold values 0..width inclusive.
    function automatic int cycles_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/comparator_cell.sv
// rtl/comparator_cell.sv - 1-bit magnitude compare cell with signed-MSB sense inversion
module comparator_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic msb_signed,
    output logic gt_bit,
    output logic lt_bit
);

    logic raw_gt;
    logic raw_lt;

    assign raw_gt = a_bit & ~b_bit;
    assign raw_lt = ~a_bit & b_bit;

    // On a two's-complement sign bit a 1 marks the smaller operand.
    assign gt_bit = msb_signed ? raw_lt : raw_gt;
    assign lt_bit = msb_signed ? raw_gt : raw_lt;

endmodule

// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - bit-serial MSB-first magnitude comparator with valid/ready handshakes
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SIGNED_EN  = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         is_signed,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         gt,
    output logic                         eq,
    output logic                         lt,
    output logic                         busy,
    output logic [cycles_w(WIDTH)-1:0]   cycles
);

    localparam int CW    = cycles_w(WIDTH);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [IDX_W-1:0] idx;
    logic             cell_gt;
    logic             cell_lt;
    cmp_res_t         bit_res;
    logic             latched;
    logic             last_bit;

    comparator_cell u_cell (
        .a_bit      (a_q[idx]),
        .b_bit      (b_q[idx]),
        .msb_signed (signed_q && (idx == MSB_IDX)),
        .gt_bit     (cell_gt),
        .lt_bit     (cell_lt)
    );

    always_comb begin
        bit_res = CMP_EQ;
        if (cell_gt)
            bit_res = CMP_GT;
        else if (cell_lt)
            bit_res = CMP_LT;
    end

    assign latched  = gt | lt;
    assign last_bit = (idx == '0);

    assign start_ready = (state == IDLE);
    assign busy        = (state == SCAN);
    assign res_valid   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_valid) state_next = SCAN;
            SCAN: begin
                if (last_bit)
                    state_next = DONE;
                else if ((EARLY_EXIT != 0) && !latched && (bit_res != CMP_EQ))
                    state_next = DONE;
            end
            DONE: if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx      <= '0;
            cycles   <= '0;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= is_signed && (SIGNED_EN != 0);
                        idx      <= MSB_IDX;
                        cycles   <= '0;
                        gt       <= 1'b0;
                        eq       <= 1'b0;
                        lt       <= 1'b0;
                    end
                end
                SCAN: begin
                    cycles <= cycles + CW'(1);
                    // Only the most significant difference decides the result.
                    if (!latched) begin
                        if (bit_res == CMP_GT)
                            gt <= 1'b1;
                        else if (bit_res == CMP_LT)
                            lt <= 1'b1;
                        else if (last_bit)
                            eq <= 1'b1;
                    end
                    if (!last_bit)
                        idx <= idx - IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
